shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage CPU.
- Sequences each transaction with a 4-state FSM and returns read data with a one-cycle ready pulse.
- Generates the stall signals that freeze the PC/IF_ID (fetch) or the whole pipeline (data).
- Includes a watchdog that flags a non-responding memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 16, BUSY cycles without mem_ack before the transaction is aborted; legal range 2..255

Ports:
clk  input  1  system clock, all flops on posedge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request, held until if_ready
if_addr  input  ADDR_W  fetch address (PC)
if_rdata  output  DATA_W  fetched instruction, registered
if_ready  output  1  one-cycle pulse, fetch complete
dm_read  input  1  data read request (EX_MEM memRead), held until dm_ready
dm_write  input  1  data write request (EX_MEM memWrite), held until dm_ready
dm_addr  input  ADDR_W  data address (EX_MEM ALU result)
dm_wdata  input  DATA_W  store data
dm_rdata  output  DATA_W  load data, registered
dm_ready  output  1  one-cycle pulse, data access complete
mem_en  output  1  memory transaction active, registered
mem_we  output  1  write strobe, valid while mem_en
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, sampled only while mem_en=1
stall_fetch  output  1  combinational: if_req & ~if_ready
stall_pipe  output  1  combinational: (dm_read|dm_write) & ~dm_ready
err_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_en, mem_we, if_ready, dm_ready and err_timeout are 0; mem_addr, mem_wdata, if_rdata and dm_rdata are 0; watchdog counter is 0. Reset mid-transaction abandons it, with no ready pulse.
- Registered states: IDLE, BUSY_D, BUSY_I, DONE.
- IDLE:
  - If dm_read|dm_write: latch dm_addr/dm_wdata into mem_addr/mem_wdata; mem_we=dm_write; mem_en=1; go to BUSY_D.
  - Else if if_req: latch if_addr; mem_we=0; mem_en=1; go to BUSY_I.
  - Data always wins a simultaneous request. The fetch is granted after the data transaction's DONE cycle.
- BUSY_x: mem_en, mem_we, mem_addr and mem_wdata are stable for the whole state. The watchdog counts each cycle without mem_ack.
  - mem_ack=1: capture mem_rdata into if_rdata (BUSY_I) or dm_rdata (BUSY_D; unchanged on a write). Pulse the matching ready for the next cycle, clear mem_en and mem_we, clear the counter, go to DONE.
  - Counter reaches TIMEOUT-1 without ack: set err_timeout, force the captured rdata to 0, pulse ready, clear mem_en, go to DONE.
- DONE: exactly one cycle with ready=1. No grant is issued, so a requester still holding req this cycle is not re-served. Next state is IDLE.
- Latency: request visible at edge 0 → mem_en=1 after edge 0 → ack sampled at edge k (k≥1) → ready=1 during cycle k+1 → earliest new grant at edge k+2.
- dm_read and dm_write both high: treated as a write.
- Requester drops req mid-transaction: the transaction still completes and the ready pulse is still issued.
- mem_ack while mem_en=0: ignored.
- err_timeout is cleared only by reset.
- A read issued in the same transaction as a write does not exist; each grant is exactly one access.

Decomposition:
- Package cpu_mem_pkg holds:
  - the state enum (IDLE, BUSY_D, BUSY_I, DONE);
  - ADDR_W/DATA_W defaults;
  - the abort read value constant (0).
- One sub-module is natural: mem_watchdog. It is a saturating counter with clear, enable and TIMEOUT compare, and outputs an expire pulse.
- All remaining logic lives in the arbiter.

Test Plan:
1. Reset and fetch: hold rst_n=0 for 3 cycles, release. Drive if_req=1, if_addr=0x10; memory acks 3 cycles after mem_en with 0x8C010004. Expect mem_addr=0x10 and mem_we=0, then if_ready for one cycle with if_rdata=0x8C010004. stall_fetch is high until that cycle.
2. Simultaneous requests: if_req (addr 0x20) and dm_read (addr 0x100) rise in the same cycle; ack latency is 1. Expect the 0x100 access first and dm_ready; one DONE cycle; then the 0x20 access and if_ready. stall_pipe is low once dm_ready has pulsed.
3. Store: dm_write=1, dm_addr=0x40, dm_wdata=0xDEADBEEF. Expect mem_we=1 with mem_wdata=0xDEADBEEF stable until ack, dm_ready pulse, and dm_rdata unchanged.
4. Back-to-back fetches with if_req held high across the ready cycle: expect exactly one DONE bubble, then a second grant.
5. Watchdog with TIMEOUT=16 and no ack ever: expect dm_ready at cycle 16 after grant, dm_rdata=0, err_timeout=1 persisting through later good transactions until rst_n=0.
6. Reset mid-transaction: assert rst_n=0 while in BUSY_I. Expect mem_en=0 immediately (async), no if_ready pulse, and state IDLE after release.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory arbiter: FSM state type,
// default bus widths and the read value returned by an aborted access.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Read data handed back when the watchdog abandons a transaction
    localparam logic [31:0] ABORT_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Watchdog for a pending memory transaction: counts cycles without an
// acknowledge and raises a one-cycle expire pulse when the limit is hit.
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // Expire fires on the idle cycle that would carry the count to
    // TIMEOUT-1, so the owner leaves BUSY on that same edge.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 2);

    logic [7:0] cnt;

    assign expire = en & (cnt == LAST_CNT);

    // Saturating idle-cycle counter, cleared on ack, on expiry and outside BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr || expire) begin
            cnt <= 8'd0;
        end else if (en && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch port and the data port of the 5-stage pipeline.
// Data requests win ties; every grant is exactly one access followed by a
// single DONE cycle in which the matching ready pulses.
module shared_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    // data port
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    // pipeline control
    output logic              stall_fetch,
    output logic              stall_pipe,
    output logic              err_timeout
);

    arb_state_t state;

    logic busy;
    logic ack_ok;
    logic wd_expire;
    logic finish;
    logic dm_any;

    assign busy   = (state == BUSY_D) || (state == BUSY_I);
    // mem_ack only counts while a transaction is actually outstanding
    assign ack_ok = busy & mem_ack;
    assign finish = ack_ok | wd_expire;
    assign dm_any = dm_read | dm_write;

    // A requester stays stalled until the cycle its ready pulse is seen
    assign stall_fetch = if_req & ~if_ready;
    assign stall_pipe  = dm_any & ~dm_ready;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~busy | mem_ack),
        .en     (busy & ~mem_ack),
        .expire (wd_expire)
    );

    // Transaction sequencer: grants, holds the memory bus stable, retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_any) begin
                        // a simultaneous read+write is issued as a write
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_we    <= dm_write;
                        mem_en    <= 1'b1;
                        state     <= BUSY_D;
                    end else if (if_req) begin
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_en    <= 1'b1;
                        state     <= BUSY_I;
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (finish) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // no grant here: a requester still holding req waits a cycle
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read-data capture and the one-cycle ready pulses for both ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
        end else begin
            if_ready <= (state == BUSY_I) && finish;
            dm_ready <= (state == BUSY_D) && finish;
            if ((state == BUSY_I) && finish) begin
                if_rdata <= ack_ok ? mem_rdata : DATA_W'(ABORT_RDATA);
            end
            // stores leave the load register untouched
            if ((state == BUSY_D) && finish && !mem_we) begin
                dm_rdata <= ack_ok ? mem_rdata : DATA_W'(ABORT_RDATA);
            end
        end
    end

    // Sticky timeout flag, only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (wd_expire) begin
            err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed scenarios plus
// randomized episodes scored against a transaction-level timing model.
`timescale 1ns/1ps
module tb_shared_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_read = 1'b0;
    logic              dm_write = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              stall_fetch;
    logic              stall_pipe;
    logic              err_timeout;

    always #5 clk = ~clk;

    shared_mem_arbiter #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .if_req (if_req), .if_addr (if_addr), .if_rdata (if_rdata), .if_ready (if_ready),
        .dm_read (dm_read), .dm_write (dm_write), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata), .dm_ready (dm_ready),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .mem_ack (mem_ack),
        .stall_fetch (stall_fetch), .stall_pipe (stall_pipe), .err_timeout (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    // memory contents seen by the responder, and the model's own copy
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];

    int  resp_q [$];      // ack latency per grant, 0 = never ack
    int  fetch_lat [$];   // latencies for the fetches of the next episode
    bit  noise = 1'b0;    // random acks while mem_en is low
    bit  both_hi = 1'b0;  // drive dm_read together with dm_write
    bit  resp_active = 1'b0;
    int  resp_n = 0;
    int  resp_lat = 0;

    // model state
    logic [31:0] model_dm = '0;
    bit          model_err = 1'b0;

    // Memory responder: acks the n-th cycle after mem_en rises
    always @(negedge clk) begin
        if (mem_en) begin
            if (!resp_active) begin
                resp_active = 1'b1;
                resp_n = 0;
                resp_lat = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
            end
            resp_n++;
            if (resp_lat != 0 && resp_n == resp_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr[9:2]] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = mem_arr[mem_addr[9:2]];
                end
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            resp_active = 1'b0;
            mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One episode: optional data access plus n_if fetches (if_req held
    // across ready, next PC presented in the ready cycle). Sample e is the
    // negedge after the e-th posedge following the request.
    task automatic episode(input string tag, input bit do_dm, input bit dm_we,
                           input logic [31:0] d_addr, input logic [31:0] d_wdata,
                           input int d_lat, input int n_if, input logic [31:0] i_addr);
        int exp_g [$]; logic [31:0] exp_ga [$]; logic exp_gw [$]; logic [31:0] exp_gd [$];
        int exp_r [$]; bit exp_rk [$]; logic [31:0] exp_rd [$];
        int obs_g [$]; logic [31:0] obs_ga [$]; logic obs_gw [$]; logic [31:0] obs_gd [$];
        int obs_r [$]; bit obs_rk [$]; logic [31:0] obs_rd [$];
        int g, r, leff, lat, last_r, last_ri, d_r, fi, sf, sp, unstable, n;
        bit ab, prev_en, lw;
        logic [31:0] a, la, lwd;
        g = 1; last_r = 0; last_ri = 0; d_r = 0;
        if (do_dm) begin
            ab = (d_lat == 0) || (d_lat > TIMEOUT - 1);
            leff = ab ? TIMEOUT - 1 : d_lat;
            r = g + leff;
            exp_g.push_back(g); exp_ga.push_back(d_addr); exp_gw.push_back(dm_we); exp_gd.push_back(d_wdata);
            if (dm_we) begin
                if (!ab) ref_mem[d_addr[9:2]] = d_wdata;
            end else begin
                model_dm = ab ? 32'h0 : ref_mem[d_addr[9:2]];
            end
            exp_r.push_back(r); exp_rk.push_back(1'b1); exp_rd.push_back(model_dm);
            model_err |= ab;
            resp_q.push_back(d_lat);
            d_r = r; last_r = r; g = r + 2;
        end
        for (int j = 0; j < n_if; j++) begin
            lat = fetch_lat[j];
            a = i_addr + 32'(4 * j);
            ab = (lat == 0) || (lat > TIMEOUT - 1);
            leff = ab ? TIMEOUT - 1 : lat;
            r = g + leff;
            exp_g.push_back(g); exp_ga.push_back(a); exp_gw.push_back(1'b0); exp_gd.push_back(32'h0);
            exp_r.push_back(r); exp_rk.push_back(1'b0); exp_rd.push_back(ab ? 32'h0 : ref_mem[a[9:2]]);
            model_err |= ab;
            resp_q.push_back(lat);
            last_r = r; last_ri = r; g = r + 2;
        end

        @(negedge clk);
        dm_write = do_dm & dm_we;
        dm_read  = do_dm & (~dm_we | both_hi);
        dm_addr  = d_addr;
        dm_wdata = d_wdata;
        if_req   = (n_if > 0);
        if_addr  = i_addr;
        prev_en = 1'b0; la = '0; lw = 1'b0; lwd = '0;
        fi = 0; sf = 0; sp = 0; unstable = 0;
        for (int e = 1; e <= last_r + 1; e++) begin
            @(negedge clk);
            if (mem_en && !prev_en) begin
                obs_g.push_back(e); obs_ga.push_back(mem_addr); obs_gw.push_back(mem_we); obs_gd.push_back(mem_wdata);
            end else if (mem_en && (mem_addr !== la || mem_we !== lw || mem_wdata !== lwd)) begin
                unstable++;
            end
            prev_en = mem_en; la = mem_addr; lw = mem_we; lwd = mem_wdata;
            if (stall_fetch) sf++;
            if (stall_pipe) sp++;
            if (dm_ready) begin
                obs_r.push_back(e); obs_rk.push_back(1'b1); obs_rd.push_back(dm_rdata);
                dm_read = 1'b0; dm_write = 1'b0;
            end
            if (if_ready) begin
                obs_r.push_back(e); obs_rk.push_back(1'b0); obs_rd.push_back(if_rdata);
                fi++;
                if (fi < n_if) if_addr = i_addr + 32'(4 * fi);
                else if_req = 1'b0;
            end
        end
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        resp_q.delete();

        check($sformatf("%s grant count", tag), obs_g.size(), exp_g.size());
        n = (obs_g.size() < exp_g.size()) ? obs_g.size() : exp_g.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s grant%0d cycle", tag, i), obs_g[i], exp_g[i]);
            check($sformatf("%s grant%0d addr", tag, i), obs_ga[i], exp_ga[i]);
            check($sformatf("%s grant%0d we", tag, i), 32'(obs_gw[i]), 32'(exp_gw[i]));
            if (exp_gw[i]) check($sformatf("%s grant%0d wdata", tag, i), obs_gd[i], exp_gd[i]);
        end
        check($sformatf("%s ready count", tag), obs_r.size(), exp_r.size());
        n = (obs_r.size() < exp_r.size()) ? obs_r.size() : exp_r.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s ready%0d cycle", tag, i), obs_r[i], exp_r[i]);
            check($sformatf("%s ready%0d port", tag, i), 32'(obs_rk[i]), 32'(exp_rk[i]));
            check($sformatf("%s ready%0d rdata", tag, i), obs_rd[i], exp_rd[i]);
        end
        check($sformatf("%s bus stable", tag), unstable, 0);
        check($sformatf("%s stall_fetch cycles", tag), sf, (n_if > 0) ? last_ri - n_if : 0);
        check($sformatf("%s stall_pipe cycles", tag), sp, do_dm ? d_r - 1 : 0);
        check($sformatf("%s dm_rdata", tag), dm_rdata, model_dm);
        check($sformatf("%s err_timeout", tag), 32'(err_timeout), 32'(model_err));
    endtask

    initial begin
        int cnt;
        bit rd, rw;
        int rn, rlat;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[4] = 32'h8C01_0004;
        ref_mem[4] = 32'h8C01_0004;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_en", 32'(mem_en), 0);
        check("reset mem_we", 32'(mem_we), 0);
        check("reset if_ready", 32'(if_ready), 0);
        check("reset dm_ready", 32'(dm_ready), 0);
        check("reset err_timeout", 32'(err_timeout), 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset if_rdata", if_rdata, 0);
        check("reset dm_rdata", dm_rdata, 0);
        rst_n = 1'b1;

        // single fetch, ack 3 cycles after mem_en
        fetch_lat = '{3};
        episode("fetch", 1'b0, 1'b0, 32'h0, 32'h0, 0, 1, 32'h10);

        // simultaneous data read and fetch, latency 1
        fetch_lat = '{1};
        episode("simul", 1'b1, 1'b0, 32'h100, 32'h0, 1, 1, 32'h20);

        // store, then read it back
        fetch_lat.delete();
        episode("store", 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4, 0, 32'h0);
        episode("load back", 1'b1, 1'b0, 32'h40, 32'h0, 2, 0, 32'h0);

        // back-to-back fetches with if_req held across ready
        fetch_lat = '{2, 2};
        episode("b2b fetch", 1'b0, 1'b0, 32'h0, 32'h0, 0, 2, 32'h80);

        // watchdog on a read that is never acked, then a good transaction
        fetch_lat.delete();
        episode("timeout", 1'b1, 1'b0, 32'h84, 32'h0, 0, 0, 32'h0);
        fetch_lat = '{2};
        episode("after timeout", 1'b0, 1'b0, 32'h0, 32'h0, 0, 1, 32'h88);

        // randomized episodes with spurious acks while idle
        noise = 1'b1;
        for (int k = 0; k < 30; k++) begin
            rd = bit'($urandom_range(0, 1));
            rw = rd ? bit'($urandom_range(0, 1)) : 1'b0;
            both_hi = rw ? bit'($urandom_range(0, 1)) : 1'b0;
            rn = rd ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
            if (rw) rlat = int'($urandom_range(1, 8));
            else if ($urandom_range(0, 9) == 0) rlat = 0;
            else rlat = int'($urandom_range(1, 8));
            fetch_lat.delete();
            for (int j = 0; j < rn; j++) begin
                if ($urandom_range(0, 7) == 0) fetch_lat.push_back(TIMEOUT - 1);
                else fetch_lat.push_back(int'($urandom_range(1, 6)));
            end
            episode($sformatf("rand%0d", k), rd, rw, {22'h0, 8'($urandom), 2'b00}, $urandom,
                    rlat, rn, {22'h0, 8'($urandom), 2'b00});
        end
        noise = 1'b0;
        both_hi = 1'b0;

        // reset while a fetch is outstanding
        resp_q.push_back(0);
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h30;
        repeat (3) @(negedge clk);
        check("mid-rst mem_en before", 32'(mem_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-rst mem_en async", 32'(mem_en), 0);
        check("mid-rst if_ready", 32'(if_ready), 0);
        check("mid-rst err_timeout", 32'(err_timeout), 0);
        @(negedge clk);
        if_req = 1'b0;
        rst_n = 1'b1;
        resp_q.delete();
        model_err = 1'b0;
        model_dm = '0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_ready || mem_en) cnt++;
        end
        check("post-rst quiet cycles", cnt, 0);
        check("post-rst if_rdata", if_rdata, 0);

        // fresh fetch from IDLE, ack exactly on the last allowed cycle
        fetch_lat = '{TIMEOUT - 1};
        episode("ack at limit", 1'b0, 1'b0, 32'h0, 32'h0, 0, 1, 32'h10);
        episode("read at limit", 1'b1, 1'b0, 32'h100, 32'h0, TIMEOUT - 1, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
